locked_reg_access_arbiter: RTL
==============================

Name: locked_reg_access_arbiter

Overview:
- Arbitrates register-write traffic from two requesters, one trusted and one untrusted, onto a small bank of lockable 16-bit registers.
- Each register has a sticky lock bit.
  - Untrusted writes to a locked register are denied.
  - Trusted writes always commit.
- Provides a combinational read port and exports the lock vector for status.
- Sits between the bus bridges and the configuration register bank.

Parameters:
- DATA_W, 16, register and write-data width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of implemented registers; must be at most 2**ADDR_W.

Ports:
- Clk  in  1  clock.
- resetn  in  1  reset.
- t_req  in  1  trusted write request; held until t_ack.
- t_addr  in  ADDR_W  trusted target address.
- t_wdata  in  DATA_W  trusted write data.
- t_lock  in  1  set the target's lock bit when this trusted write commits.
- t_ack  out  1  one-cycle completion pulse to the trusted requester.
- t_err  out  1  valid with t_ack; 1 means the write was rejected.
- u_req  in  1  untrusted write request; held until u_ack.
- u_addr  in  ADDR_W  untrusted target address.
- u_wdata  in  DATA_W  untrusted write data.
- u_ack  out  1  one-cycle completion pulse to the untrusted requester.
- u_err  out  1  valid with u_ack; 1 means the write was rejected.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  combinational read of regs[rd_addr]; 0 if out of range.
- lock_vec  out  NUM_REGS  current lock bits.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is Clk.
  - On reset: all registers = 0, lock_vec = 0, t_ack/t_err/u_ack/u_err = 0, busy = 0.
  - FSM goes to IDLE; round-robin pointer favours trusted.
  - Reset asserted mid-transaction aborts it: no write, no ack.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the pointer's favourite.
  - On grant: latch winner id, addr, data, and lock flag (lock flag forced to 0 for untrusted); go to EXEC.
- EXEC, one cycle: evaluate the latched request.
  - addr >= NUM_REGS: deny; no write; err = 1.
  - Untrusted and lock_vec[addr] = 1: deny; err = 1.
  - Otherwise: regs[addr] <= data; err = 0.
  - If trusted with lock flag = 1 and no deny: lock_vec[addr] <= 1 in the same edge as the data write.
  - Go to RESP.
- RESP:
  - Drive the winner's ack = 1 with its err for exactly one cycle; the other requester's ack stays 0.
  - Pointer toggles to favour the non-winner.
  - Return to IDLE.
- Latency: from the IDLE edge that samples req to the ack pulse is 3 cycles; the write is visible on rd_data one cycle before ack.
- Handshake:
  - Requester must hold req and payload stable until ack.
  - A request is latched at grant; dropping req afterwards does not abort it.
  - A requester that keeps req high in the cycle after ack is treated as a new request.
- Lock bits:
  - Sticky; cleared only by reset.
  - Setting an already-set lock bit is harmless.
  - Trusted writes to locked registers commit.
- Fairness: under continuous contention, grants alternate T, U, T, U...
- Reads are never blocked, including reads of the register being written in EXEC; the new value appears after the EXEC edge.

Optional Feature:
- Macro: LOCKED_REG_DENY_COUNT_EN.
- Defined:
  - Adds output deny_cnt [7:0], reset to 0.
  - Increments on every EXEC cycle that denies a request (locked or out-of-range).
  - Saturates at 255.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then trusted write addr 2 data 0x1234, t_lock = 0 -> t_ack after 3 cycles, t_err = 0; rd_data(2) = 0x1234; lock_vec = 0x00.
- Trusted write addr 5 data 0xBEEF with t_lock = 1, then untrusted write addr 5 data 0x0000 -> lock_vec = 0x20; u_ack with u_err = 1; rd_data(5) stays 0xBEEF; deny_cnt = 1 if the macro is enabled.
- With register 5 locked, trusted write addr 5 data 0x5555 -> t_err = 0; rd_data(5) = 0x5555.
- t_req and u_req asserted the same cycle and held for four transactions -> ack order T, U, T, U; each ack is a single cycle; no overlapping acks.
- Untrusted write addr 7 with NUM_REGS = 6 -> u_err = 1; no register changes.
- resetn pulsed low during EXEC of an untrusted write to addr 1 -> no ack; regs[1] = 0; busy = 0; next request completes normally.

Source files
------------

// File: rtl/locked_reg_access_arbiter.sv
// Purpose: arbitrates trusted/untrusted register writes onto a bank of lockable registers.
// Latency: ack pulses 3 cycles after the sampling edge; the write is readable one cycle earlier.
// Backpressure: req/payload held until ack; one transaction in flight, other requester waits.
//
// Ports:
//   Clk, resetn                      clock, async active-low reset
//   t_req/t_addr/t_wdata/t_lock      trusted write request (t_lock sets the target's lock bit)
//   t_ack/t_err                      trusted completion pulse and reject flag
//   u_req/u_addr/u_wdata             untrusted write request
//   u_ack/u_err                      untrusted completion pulse and reject flag
//   rd_addr/rd_data                  combinational read port (0 when out of range)
//   lock_vec                         current lock bits
//   busy                             transaction in flight
//   deny_cnt                         saturating deny counter, only with LOCKED_REG_DENY_COUNT_EN
module locked_reg_access_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic                t_req,
  input  logic [ADDR_W-1:0]   t_addr,
  input  logic [DATA_W-1:0]   t_wdata,
  input  logic                t_lock,
  output logic                t_ack,
  output logic                t_err,
  input  logic                u_req,
  input  logic [ADDR_W-1:0]   u_addr,
  input  logic [DATA_W-1:0]   u_wdata,
  output logic                u_ack,
  output logic                u_err,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] lock_vec,
`ifdef LOCKED_REG_DENY_COUNT_EN
  output logic [7:0]          deny_cnt,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic                r_ptr_u;      // 1: untrusted wins the next tie
  logic                r_win_u;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_lock_flag;
  logic                r_err;
  logic                r_t_ack;
  logic                r_u_ack;
  logic                r_ack_err;
`ifdef LOCKED_REG_DENY_COUNT_EN
  logic [7:0]          r_deny_cnt;
`endif

  logic                w_t_req_eff;
  logic                w_u_req_eff;
  logic                w_grant_u;
  logic                w_in_range;
  logic                w_deny;
  logic [DATA_W-1:0]   w_rd_data;

  // During the ack cycle the acked requester still shows its old req; it is
  // only a new request if req is still high in the cycle after ack.
  assign w_t_req_eff = t_req & ~r_t_ack;
  assign w_u_req_eff = u_req & ~r_u_ack;
  assign w_grant_u   = w_u_req_eff & (~w_t_req_eff | r_ptr_u);

  assign w_in_range  = (int'(r_addr) < NUM_REGS);
  assign w_deny      = ~w_in_range | (r_win_u & r_lock[r_addr]);

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_t_req_eff || w_u_req_eff) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_lock      <= '0;
      r_ptr_u     <= 1'b0;
      r_win_u     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_lock_flag <= 1'b0;
      r_err       <= 1'b0;
      r_t_ack     <= 1'b0;
      r_u_ack     <= 1'b0;
      r_ack_err   <= 1'b0;
`ifdef LOCKED_REG_DENY_COUNT_EN
      r_deny_cnt  <= '0;
`endif
    end else begin
      r_t_ack <= 1'b0;
      r_u_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_t_req_eff || w_u_req_eff) begin
            r_win_u     <= w_grant_u;
            r_addr      <= w_grant_u ? u_addr  : t_addr;
            r_data      <= w_grant_u ? u_wdata : t_wdata;
            r_lock_flag <= w_grant_u ? 1'b0    : t_lock;
          end
        end
        S_EXEC: begin
          r_err <= w_deny;
          if (!w_deny) begin
            r_regs[r_addr] <= r_data;
            if (!r_win_u && r_lock_flag) r_lock[r_addr] <= 1'b1;
          end
`ifdef LOCKED_REG_DENY_COUNT_EN
          if (w_deny && r_deny_cnt != 8'hFF) r_deny_cnt <= r_deny_cnt + 8'd1;
`endif
        end
        S_RESP: begin
          r_t_ack   <= ~r_win_u;
          r_u_ack   <= r_win_u;
          r_ack_err <= r_err;
          r_ptr_u   <= ~r_win_u;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (int'(rd_addr) < NUM_REGS) w_rd_data = r_regs[rd_addr];
  end

  assign rd_data  = w_rd_data;
  assign lock_vec = r_lock;
  assign t_ack    = r_t_ack;
  assign t_err    = r_t_ack & r_ack_err;
  assign u_ack    = r_u_ack;
  assign u_err    = r_u_ack & r_ack_err;
  assign busy     = (r_state != S_IDLE);
`ifdef LOCKED_REG_DENY_COUNT_EN
  assign deny_cnt = r_deny_cnt;
`endif

endmodule
